// File: rtl/comm_pkg.sv
// Shared message-type constants, payload limits and framer state encoding.
// Define COMM_TX_CHECKSUM_EN to append an XOR checksum byte to every frame.
package comm_pkg;

  localparam logic [7:0] MSG_SYS_RESET = 8'h01;
  localparam logic [7:0] MSG_READ_REG  = 8'h02;
  localparam logic [7:0] MSG_WRITE_REG = 8'h03;
  localparam logic [7:0] MSG_READ_RAM  = 8'h04;
  localparam logic [7:0] MSG_WRITE_RAM = 8'h05;

  localparam logic [7:0] MAX_PAYLOAD_PLAIN = 8'd254;
  localparam logic [7:0] MAX_PAYLOAD_CSUM  = 8'd253;

`ifdef COMM_TX_CHECKSUM_EN
  localparam logic [7:0] MAX_PAYLOAD = MAX_PAYLOAD_CSUM;
  // Length byte counts type + payload + checksum.
  localparam logic [7:0] LEN_EXTRA   = 8'd2;
`else
  localparam logic [7:0] MAX_PAYLOAD = MAX_PAYLOAD_PLAIN;
  localparam logic [7:0] LEN_EXTRA   = 8'd1;
`endif

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN     = 3'd1,
    S_TYPE    = 3'd2,
    S_PAYLOAD = 3'd3,
    S_WAIT    = 3'd4
`ifdef COMM_TX_CHECKSUM_EN
    ,S_CSUM   = 3'd5
`endif
  } tx_state_e;

endpackage

// File: rtl/comm_tx_framer.sv
// Builds length/type/payload frames and feeds them byte-by-byte to a UART
// transmitter. Optional trailing XOR checksum under COMM_TX_CHECKSUM_EN.
module comm_tx_framer
  import comm_pkg::*;
#(
  parameter int GUARD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_type,
  input  logic [7:0] req_len,
  input  logic       pl_valid,
  output logic       pl_ready,
  input  logic [7:0] pl_data,
  output logic [7:0] tx_data,
  output logic       send_data,
  input  logic       busy,
  output logic       frame_done,
  output logic       req_err
);

`ifdef COMM_TX_CHECKSUM_EN
  localparam tx_state_e AFTER_PAYLOAD = S_CSUM;
`else
  localparam tx_state_e AFTER_PAYLOAD = S_IDLE;
`endif
  localparam logic [3:0] GUARD_INIT = GUARD_CYCLES[3:0];

  tx_state_e  state_q, state_d;
  tx_state_e  ret_q, ret_d;
  logic [7:0] type_q, type_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] guard_q, guard_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       send_q, send_d;
  logic       err_q, err_d;
`ifdef COMM_TX_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      ret_q     <= S_IDLE;
      type_q    <= 8'h00;
      cnt_q     <= 8'h00;
      guard_q   <= 4'h0;
      tx_data_q <= 8'h00;
      send_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef COMM_TX_CHECKSUM_EN
      csum_q    <= 8'h00;
`endif
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      type_q    <= type_d;
      cnt_q     <= cnt_d;
      guard_q   <= guard_d;
      tx_data_q <= tx_data_d;
      send_q    <= send_d;
      err_q     <= err_d;
`ifdef COMM_TX_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    type_d     = type_q;
    cnt_d      = cnt_q;
    guard_d    = guard_q;
    tx_data_d  = tx_data_q;
    send_d     = 1'b0;
    err_d      = 1'b0;
    pl_ready   = 1'b0;
    frame_done = 1'b0;
`ifdef COMM_TX_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (req_len > MAX_PAYLOAD) begin
            err_d = 1'b1;
          end else begin
            state_d = S_LEN;
            type_d  = req_type;
            cnt_d   = req_len;
          end
        end
      end
      S_LEN: begin
        if (!busy) begin
          tx_data_d = cnt_q + LEN_EXTRA;
          send_d    = 1'b1;
          guard_d   = GUARD_INIT;
          ret_d     = S_TYPE;
          state_d   = S_WAIT;
        end
      end
      S_TYPE: begin
        if (!busy) begin
          tx_data_d = type_q;
          send_d    = 1'b1;
          guard_d   = GUARD_INIT;
          ret_d     = (cnt_q != 8'd0) ? S_PAYLOAD : AFTER_PAYLOAD;
          state_d   = S_WAIT;
`ifdef COMM_TX_CHECKSUM_EN
          csum_d    = type_q;
`endif
        end
      end
      S_PAYLOAD: begin
        // cnt_q holds the number of payload bytes still to send.
        if (pl_valid && !busy) begin
          pl_ready  = 1'b1;
          tx_data_d = pl_data;
          send_d    = 1'b1;
          guard_d   = GUARD_INIT;
          cnt_d     = cnt_q - 8'd1;
          ret_d     = (cnt_q == 8'd1) ? AFTER_PAYLOAD : S_PAYLOAD;
          state_d   = S_WAIT;
`ifdef COMM_TX_CHECKSUM_EN
          csum_d    = csum_q ^ pl_data;
`endif
        end
      end
`ifdef COMM_TX_CHECKSUM_EN
      S_CSUM: begin
        if (!busy) begin
          tx_data_d = csum_q;
          send_d    = 1'b1;
          guard_d   = GUARD_INIT;
          ret_d     = S_IDLE;
          state_d   = S_WAIT;
        end
      end
`endif
      S_WAIT: begin
        // busy from the UART lags send_data, so it is ignored during the guard.
        if (guard_q != 4'd0) begin
          guard_d = guard_q - 4'd1;
        end else if (!busy) begin
          state_d    = ret_q;
          frame_done = (ret_q == S_IDLE);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign req_ready = (state_q == S_IDLE);
  assign tx_data   = tx_data_q;
  assign send_data = send_q;
  assign req_err   = err_q;

endmodule

// File: tb/tb_comm_tx_framer.sv
// Directed bench for comm_tx_framer with a simple UART busy model.
// Build with COMM_TX_CHECKSUM_EN defined to exercise the checksum variant.
module tb_comm_tx_framer;

`ifdef COMM_TX_CHECKSUM_EN
  localparam int CSUM_EN = 1;
`else
  localparam int CSUM_EN = 0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_type = 8'h00;
  logic [7:0] req_len = 8'h00;
  logic       pl_valid;
  logic       pl_ready;
  logic [7:0] pl_data;
  logic [7:0] tx_data;
  logic       send_data;
  logic       busy;
  logic       frame_done;
  logic       req_err;

  comm_tx_framer #(.GUARD_CYCLES(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_type(req_type), .req_len(req_len),
    .pl_valid(pl_valid), .pl_ready(pl_ready), .pl_data(pl_data),
    .tx_data(tx_data), .send_data(send_data), .busy(busy),
    .frame_done(frame_done), .req_err(req_err)
  );

  always #5 clk = ~clk;

  // UART model: busy for 10 cycles, starting the cycle after each launch.
  int busy_cnt = 0;
  assign busy = (busy_cnt != 0);

  logic [7:0] wire_q[$];
  int send_cnt = 0, done_cnt = 0, err_cnt = 0, plr_cnt = 0, idx = 0;

  always @(posedge clk) begin
    if (send_data) begin
      busy_cnt <= 10;
      wire_q.push_back(tx_data);
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
    if (send_data)  send_cnt <= send_cnt + 1;
    if (frame_done) done_cnt <= done_cnt + 1;
    if (req_err)    err_cnt  <= err_cnt + 1;
    if (pl_ready)   plr_cnt  <= plr_cnt + 1;
    if (pl_valid && pl_ready) idx <= idx + 1;
  end

  // Payload source: bytes pay[0..pay_n-1] offered from index base bpay.
  logic [7:0] pay [0:7];
  int  pay_n = 0, bpay = 0;
  logic pl_en = 1'b0, pl_force = 1'b0;
  assign pl_valid = pl_en && (pl_force || ((idx - bpay) < pay_n));
  assign pl_data  = pay[(idx - bpay) & 7];

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle_uart();
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    chk("uart_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic issue_req(input logic [7:0] typ, input logic [7:0] n);
    @(negedge clk);
    req_valid = 1'b1;
    req_type  = typ;
    req_len   = n;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Sends one frame from pay[0..n-1], optionally stalling after the first payload byte.
  task automatic run_frame(input string tag, input logic [7:0] typ, input int n, input bit stall);
    logic [7:0] exp[$];
    logic [7:0] cs;
    int wb, sb, db;
    wait_idle_uart();
    wb = wire_q.size(); sb = send_cnt; db = done_cnt;
    bpay = idx; pay_n = n; pl_en = 1'b1;
    issue_req(typ, n[7:0]);
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_lat_send"}, {31'd0, send_data}, 32'd1);
    chk({tag, "_lat_len"}, {24'd0, tx_data}, n + 1 + CSUM_EN);
    if (stall) begin
      for (int i = 0; i < 200 && (idx - bpay) < 1; i++) @(negedge clk);
      pl_en = 1'b0;
      repeat (50) @(negedge clk);
      chk({tag, "_stall_sends"}, send_cnt - sb, 3);
      pl_en = 1'b1;
    end
    for (int i = 0; i < 3000 && done_cnt == db; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk({tag, "_done"}, done_cnt - db, 1);
    chk({tag, "_sends"}, send_cnt - sb, n + 2 + CSUM_EN);
    exp.push_back(8'(n + 1 + CSUM_EN));
    exp.push_back(typ);
    cs = typ;
    for (int i = 0; i < n; i++) begin
      exp.push_back(pay[i]);
      cs = cs ^ pay[i];
    end
    if (CSUM_EN != 0) exp.push_back(cs);
    for (int i = 0; i < exp.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i),
          {24'd0, (wb + i < wire_q.size()) ? wire_q[wb + i] : 8'hxx}, {24'd0, exp[i]});
    pl_en = 1'b0;
  endtask

  task automatic run_reject(input string tag, input logic [7:0] n);
    int sb, eb;
    wait_idle_uart();
    sb = send_cnt; eb = err_cnt;
    issue_req(8'h02, n);
    chk({tag, "_err"}, {31'd0, req_err}, 32'd1);
    chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    chk({tag, "_err_pulse"}, {31'd0, req_err}, 32'd0);
    repeat (20) @(negedge clk);
    chk({tag, "_no_send"}, send_cnt - sb, 0);
    chk({tag, "_err_cnt"}, err_cnt - eb, 1);
  endtask

  initial begin
    int sb, pb, ib;
    #2;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_pl_ready", {31'd0, pl_ready}, 32'd0);
    chk("rst_send", {31'd0, send_data}, 32'd0);
    chk("rst_tx", {24'd0, tx_data}, 32'h00);
    chk("rst_done", {31'd0, frame_done}, 32'd0);
    chk("rst_err", {31'd0, req_err}, 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // type 0x02, two payload bytes
    pay[0] = 8'h0A; pay[1] = 8'h0B;
    run_frame("f2", 8'h02, 2, 1'b0);

    // empty payload; pl_valid held high must be ignored
    pb = plr_cnt; ib = idx;
    pl_force = 1'b1;
    run_frame("f0", 8'h01, 0, 1'b0);
    pl_force = 1'b0;
    chk("f0_no_pl_ready", plr_cnt - pb, 0);
    chk("f0_no_consume", idx - ib, 0);

    run_reject("n255", 8'd255);
    if (CSUM_EN != 0) run_reject("n254", 8'd254);

    // payload stall between bytes
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    run_frame("stall", 8'h03, 3, 1'b1);

    // reset during the wait after the type byte
    wait_idle_uart();
    sb = send_cnt;
    bpay = idx; pay_n = 1; pay[0] = 8'h77; pl_en = 1'b1;
    issue_req(8'h04, 8'd1);
    for (int i = 0; i < 200 && (send_cnt - sb) < 2; i++) @(negedge clk);
    chk("rst_mid_sends", send_cnt - sb, 2);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_mid_send", {31'd0, send_data}, 32'd0);
    chk("rst_mid_tx", {24'd0, tx_data}, 32'h00);
    chk("rst_mid_pl_ready", {31'd0, pl_ready}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("rst_mid_aborted", send_cnt - sb, 2);
    pl_en = 1'b0;
    pay[0] = 8'hAA; pay[1] = 8'hBB;
    run_frame("post_rst", 8'h02, 2, 1'b0);

    if (CSUM_EN != 0) begin
      pay[0] = 8'h12; pay[1] = 8'h34;
      run_frame("csum", 8'h05, 2, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
